rvb_crc_issue: RTL and testbench

Decode-and-issue stage directly upstream of `rvb_crc`. Accepts raw 32-bit instruction words with their rs1 operand from the execute front end, decodes the CRC32/CRC32C opcode group, and forwards legal CRC operations through a 2-entry FIFO as the `rs1` + `insn20/21/23` bundle that `rvb_crc` consumes. Non-CRC or XLEN-illegal encodings are dropped, reported on a one-cycle illegal pulse, and counted.

---
 rtl/rvb_crc_issue.sv | 136 +++++++++++++
 tb/tb_rvb_crc_issue.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvb_crc_issue.sv
// Decode-and-issue stage for rvb_crc: filters the CRC32/CRC32C opcode group and
// queues legal operations in a 2-entry in-order FIFO; rejected words are reported and counted.
module rvb_crc_issue #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            din_valid,
  output logic            din_ready,
  input  logic [31:0]     din_insn,
  input  logic [XLEN-1:0] din_rs1,
  output logic            crc_valid,
  input  logic            crc_ready,
  output logic [XLEN-1:0] crc_rs1,
  output logic            crc_insn20,
  output logic            crc_insn21,
  output logic            crc_insn23,
  output logic            ill_valid,
  output logic [31:0]     ill_insn,
  output logic [15:0]     ill_count
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] rs1;
    logic            i20;
    logic            i21;
    logic            i23;
  } entry_t;

  state_e      state_q, state_d;
  entry_t      head_q, head_d;
  entry_t      tail_q, tail_d;
  entry_t      new_entry;
  logic        ill_valid_q, ill_valid_d;
  logic [31:0] ill_insn_q, ill_insn_d;
  logic [15:0] ill_count_q, ill_count_d;

  logic push, pop, is_crc, size_ok, legal_push, ill_push;

  // din_ready depends only on registered occupancy; held low while reset is asserted.
  assign din_ready = resetn && (state_q != FULL);
  assign crc_valid = (state_q != EMPTY);

  assign push = din_valid && din_ready;
  assign pop  = crc_valid && crc_ready;

  assign size_ok = (din_insn[21:20] != 2'b11) || (XLEN == 64);
  assign is_crc  = (din_insn[31:25] == 7'b0110000) && din_insn[24] && !din_insn[22] &&
                   (din_insn[14:12] == 3'b001) && (din_insn[6:0] == 7'b0010011) && size_ok;

  assign legal_push = push && is_crc;
  assign ill_push   = push && !is_crc;

  always_comb begin
    new_entry     = '0;
    new_entry.rs1 = din_rs1;
    new_entry.i20 = din_insn[20];
    new_entry.i21 = din_insn[21];
    new_entry.i23 = din_insn[23];
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      EMPTY: begin
        if (legal_push) begin
          head_d  = new_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        // With a concurrent pop the new word lands directly in the head slot.
        if (legal_push && pop) begin
          head_d = new_entry;
        end else if (legal_push) begin
          tail_d  = new_entry;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    ill_valid_d = ill_push;
    ill_insn_d  = ill_insn_q;
    ill_count_d = ill_count_q;
    if (ill_push) begin
      ill_insn_d  = din_insn;
      ill_count_d = ill_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      ill_valid_q <= 1'b0;
      ill_insn_q  <= '0;
      ill_count_q <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      ill_valid_q <= ill_valid_d;
      ill_insn_q  <= ill_insn_d;
      ill_count_q <= ill_count_d;
    end
  end

  assign crc_rs1    = head_q.rs1;
  assign crc_insn20 = head_q.i20;
  assign crc_insn21 = head_q.i21;
  assign crc_insn23 = head_q.i23;
  assign ill_valid  = ill_valid_q;
  assign ill_insn   = ill_insn_q;
  assign ill_count  = ill_count_q;

endmodule

// File: tb/tb_rvb_crc_issue.sv
// Self-checking bench for rvb_crc_issue: directed scenarios on XLEN=32 and XLEN=64
// instances plus a randomized run against a queue-based decode model.
module tb_rvb_crc_issue;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        din_valid = 1'b0;
  logic [31:0] din_insn = '0;
  logic [31:0] din_rs1 = '0;
  logic [63:0] din_rs1_64 = '0;
  logic        crc_ready = 1'b0;

  logic        din_ready, crc_valid, crc_insn20, crc_insn21, crc_insn23, ill_valid;
  logic [31:0] crc_rs1, ill_insn;
  logic [15:0] ill_count;

  logic        r64_din_ready, r64_crc_valid, r64_insn20, r64_insn21, r64_insn23, r64_ill_valid;
  logic [63:0] r64_crc_rs1;
  logic [31:0] r64_ill_insn;
  logic [15:0] r64_ill_count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  rvb_crc_issue #(.XLEN(32)) dut (
    .clock(clk), .resetn(resetn), .din_valid(din_valid), .din_ready(din_ready),
    .din_insn(din_insn), .din_rs1(din_rs1), .crc_valid(crc_valid), .crc_ready(crc_ready),
    .crc_rs1(crc_rs1), .crc_insn20(crc_insn20), .crc_insn21(crc_insn21), .crc_insn23(crc_insn23),
    .ill_valid(ill_valid), .ill_insn(ill_insn), .ill_count(ill_count)
  );

  rvb_crc_issue #(.XLEN(64)) dut64 (
    .clock(clk), .resetn(resetn), .din_valid(din_valid), .din_ready(r64_din_ready),
    .din_insn(din_insn), .din_rs1(din_rs1_64), .crc_valid(r64_crc_valid), .crc_ready(crc_ready),
    .crc_rs1(r64_crc_rs1), .crc_insn20(r64_insn20), .crc_insn21(r64_insn21), .crc_insn23(r64_insn23),
    .ill_valid(r64_ill_valid), .ill_insn(r64_ill_insn), .ill_count(r64_ill_count)
  );

  typedef struct {
    logic [31:0] rs1;
    logic        b20;
    logic        b21;
    logic        b23;
  } bundle_t;

  // Architectural decode: fixed fields of the CRC group, and size d needs a 64-bit datapath.
  function automatic bit model_legal(input logic [31:0] w, input bit xlen64);
    if ((w & 32'hFF40707F) != 32'h61001013) return 1'b0;
    if (w[21:20] == 2'b11 && !xlen64) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] gen_word();
    int unsigned r;
    int unsigned flips[4];
    logic [31:0] w;
    flips = '{22, 24, 12, 25};
    r = $urandom_range(0, 9);
    w = 32'h61001013 | ($urandom & 32'h000F8F80) | ($urandom_range(0, 2) << 20) |
        ($urandom_range(0, 1) << 23);
    if (r == 6) w = w | 32'h00300000;
    else if (r == 7) w = w ^ (32'h1 << flips[$urandom_range(0, 3)]);
    else if (r >= 8) w = $urandom;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    din_valid = 1'b0;
    crc_ready = 1'b0;
    resetn    = 1'b0;
    tick();
    resetn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    din_valid = 1'b0;
    resetn    = 1'b0;
    #2;
    checks++;
    if ({din_ready, crc_valid, ill_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got=%b want=000", {din_ready, crc_valid, ill_valid});
    end
    checks++;
    if ({crc_rs1, crc_insn20, crc_insn21, crc_insn23, ill_insn, ill_count} !== '0) begin
      errors++;
      $display("FAIL reset_regs rs1=%h ill_insn=%h ill_count=%h want all 0", crc_rs1, ill_insn, ill_count);
    end
    tick();
    resetn = 1'b1;
    #1;
    checks++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got=%b want=1", din_ready);
    end
  endtask

  task automatic test_single();
    crc_ready = 1'b1;
    din_valid = 1'b1;
    din_insn  = 32'h61209113;
    din_rs1   = 32'hDEADBEEF;
    tick();
    din_valid = 1'b0;
    checks++;
    if ({crc_valid, crc_rs1, crc_insn20, crc_insn21, crc_insn23} !== {1'b1, 32'hDEADBEEF, 3'b010}) begin
      errors++;
      $display("FAIL single_issue got v=%b rs1=%h b20/21/23=%b%b%b want v=1 rs1=deadbeef 010",
               crc_valid, crc_rs1, crc_insn20, crc_insn21, crc_insn23);
    end
    tick();
    checks++;
    if (crc_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_popped crc_valid=%b want=0", crc_valid);
    end
  endtask

  task automatic test_back_to_back();
    crc_ready = 1'b0;
    din_valid = 1'b1;
    din_insn  = 32'h61209113;
    din_rs1   = 32'd1;
    tick();
    checks++;
    if ({crc_valid, din_ready, crc_rs1} !== {2'b11, 32'd1}) begin
      errors++;
      $display("FAIL b2b_first got v=%b rdy=%b rs1=%h want 1 1 1", crc_valid, din_ready, crc_rs1);
    end
    din_insn = 32'h61809113;
    din_rs1  = 32'd2;
    tick();
    checks++;
    if ({din_ready, crc_rs1} !== {1'b0, 32'd1}) begin
      errors++;
      $display("FAIL b2b_full got rdy=%b rs1=%h want 0 1", din_ready, crc_rs1);
    end
    din_insn = 32'h61009113;
    din_rs1  = 32'd3;
    tick();
    checks++;
    if ({din_ready, crc_valid, crc_rs1, crc_insn20, crc_insn21, crc_insn23} !== {2'b01, 32'd1, 3'b010}) begin
      errors++;
      $display("FAIL b2b_stall_stable got rdy=%b v=%b rs1=%h bits=%b%b%b want 0 1 1 010",
               din_ready, crc_valid, crc_rs1, crc_insn20, crc_insn21, crc_insn23);
    end
    crc_ready = 1'b1;
    tick();
    checks++;
    if ({din_ready, crc_valid, crc_rs1, crc_insn20, crc_insn21, crc_insn23} !== {2'b11, 32'd2, 3'b001}) begin
      errors++;
      $display("FAIL b2b_second got rdy=%b v=%b rs1=%h bits=%b%b%b want 1 1 2 001",
               din_ready, crc_valid, crc_rs1, crc_insn20, crc_insn21, crc_insn23);
    end
    tick();
    din_valid = 1'b0;
    checks++;
    if ({crc_valid, crc_rs1, crc_insn20, crc_insn21, crc_insn23} !== {1'b1, 32'd3, 3'b000}) begin
      errors++;
      $display("FAIL b2b_third got v=%b rs1=%h bits=%b%b%b want 1 3 000",
               crc_valid, crc_rs1, crc_insn20, crc_insn21, crc_insn23);
    end
    tick();
    checks++;
    if (crc_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drained crc_valid=%b want=0", crc_valid);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    crc_ready = 1'b1;
    din_valid = 1'b1;
    din_insn  = 32'h00000033;
    tick();
    din_valid = 1'b0;
    checks++;
    if ({crc_valid, ill_valid, ill_insn, ill_count} !== {2'b01, 32'h00000033, 16'd1}) begin
      errors++;
      $display("FAIL illegal_report got v=%b ill=%b insn=%h cnt=%0d want 0 1 00000033 1",
               crc_valid, ill_valid, ill_insn, ill_count);
    end
    din_valid = 1'b1;
    din_insn  = 32'h61209117;
    tick();
    din_insn = 32'hFFFFFFFF;
    checks++;
    if ({ill_valid, ill_insn, ill_count} !== {1'b1, 32'h61209117, 16'd2}) begin
      errors++;
      $display("FAIL illegal_b2b1 got ill=%b insn=%h cnt=%0d want 1 61209117 2", ill_valid, ill_insn, ill_count);
    end
    tick();
    din_valid = 1'b0;
    checks++;
    if ({ill_valid, ill_insn, ill_count} !== {1'b1, 32'hFFFFFFFF, 16'd3}) begin
      errors++;
      $display("FAIL illegal_b2b2 got ill=%b insn=%h cnt=%0d want 1 ffffffff 3", ill_valid, ill_insn, ill_count);
    end
    tick();
    checks++;
    if ({ill_valid, crc_valid, ill_count} !== {2'b00, 16'd3}) begin
      errors++;
      $display("FAIL illegal_pulse_end got ill=%b v=%b cnt=%0d want 0 0 3", ill_valid, crc_valid, ill_count);
    end
  endtask

  task automatic test_xlen();
    do_reset();
    crc_ready  = 1'b0;
    din_valid  = 1'b1;
    din_insn   = 32'h61309113;
    din_rs1    = 32'h89ABCDEF;
    din_rs1_64 = 64'h0123456789ABCDEF;
    tick();
    din_valid = 1'b0;
    checks++;
    if ({crc_valid, ill_valid, ill_count} !== {2'b01, 16'd1}) begin
      errors++;
      $display("FAIL xlen32_d_reject got v=%b ill=%b cnt=%0d want 0 1 1", crc_valid, ill_valid, ill_count);
    end
    checks++;
    if ({r64_crc_valid, r64_ill_valid, r64_crc_rs1, r64_insn20, r64_insn21, r64_insn23} !==
        {2'b10, 64'h0123456789ABCDEF, 3'b110}) begin
      errors++;
      $display("FAIL xlen64_d_issue got v=%b ill=%b rs1=%h bits=%b%b%b want 1 0 0123456789abcdef 110",
               r64_crc_valid, r64_ill_valid, r64_crc_rs1, r64_insn20, r64_insn21, r64_insn23);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    crc_ready = 1'b0;
    din_valid = 1'b1;
    din_insn  = 32'h61209113;
    din_rs1   = 32'h11111111;
    tick();
    din_rs1 = 32'h22222222;
    tick();
    din_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({crc_valid, din_ready, crc_rs1} !== {2'b00, 32'h0}) begin
      errors++;
      $display("FAIL reset_mid got v=%b rdy=%b rs1=%h want 0 0 0", crc_valid, din_ready, crc_rs1);
    end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checks++;
    if ({crc_valid, din_ready} !== 2'b01) begin
      errors++;
      $display("FAIL reset_mid_release got v=%b rdy=%b want 0 1", crc_valid, din_ready);
    end
    din_valid = 1'b1;
    din_rs1   = 32'h33333333;
    tick();
    din_valid = 1'b0;
    checks++;
    if ({crc_valid, crc_rs1} !== {1'b1, 32'h33333333}) begin
      errors++;
      $display("FAIL reset_mid_latency got v=%b rs1=%h want 1 33333333", crc_valid, crc_rs1);
    end
  endtask

  task automatic test_random();
    bundle_t     q[$];
    bundle_t     b;
    logic        exp_ill_valid;
    logic [31:0] exp_ill_insn;
    logic [15:0] exp_ill_count;
    int unsigned pushed, cycles;
    bit          do_push, do_pop;
    do_reset();
    exp_ill_valid = 1'b0;
    exp_ill_insn  = '0;
    exp_ill_count = '0;
    pushed = 0;
    cycles = 0;
    while (pushed < 1000 && cycles < 20000) begin
      din_valid = ($urandom_range(0, 3) != 0);
      crc_ready = ($urandom_range(0, 2) != 0);
      din_insn  = gen_word();
      din_rs1   = $urandom;
      do_pop  = crc_ready && (q.size() != 0);
      do_push = din_valid && (q.size() != 2);
      tick();
      cycles++;
      if (do_pop) void'(q.pop_front());
      exp_ill_valid = 1'b0;
      if (do_push) begin
        pushed++;
        if (model_legal(din_insn, 1'b0)) begin
          b.rs1 = din_rs1;
          b.b20 = din_insn[20];
          b.b21 = din_insn[21];
          b.b23 = din_insn[23];
          q.push_back(b);
        end else begin
          exp_ill_valid = 1'b1;
          exp_ill_insn  = din_insn;
          exp_ill_count = exp_ill_count + 16'd1;
        end
      end
      checks++;
      if ({crc_valid, din_ready, ill_valid, ill_insn, ill_count} !==
          {(q.size() != 0), (q.size() != 2), exp_ill_valid, exp_ill_insn, exp_ill_count}) begin
        errors++;
        $display("FAIL rand_ctrl cyc=%0d got v=%b rdy=%b ill=%b insn=%h cnt=%0d want v=%b rdy=%b ill=%b insn=%h cnt=%0d",
                 cycles, crc_valid, din_ready, ill_valid, ill_insn, ill_count,
                 (q.size() != 0), (q.size() != 2), exp_ill_valid, exp_ill_insn, exp_ill_count);
      end
      if (q.size() != 0) begin
        checks++;
        if ({crc_rs1, crc_insn20, crc_insn21, crc_insn23} !== {q[0].rs1, q[0].b20, q[0].b21, q[0].b23}) begin
          errors++;
          $display("FAIL rand_head cyc=%0d got rs1=%h bits=%b%b%b want rs1=%h bits=%b%b%b", cycles,
                   crc_rs1, crc_insn20, crc_insn21, crc_insn23, q[0].rs1, q[0].b20, q[0].b21, q[0].b23);
        end
      end
    end
    din_valid = 1'b0;
    checks++;
    if (pushed != 1000) begin
      errors++;
      $display("FAIL rand_budget pushed=%0d want=1000 within 20000 cycles", pushed);
    end
  endtask

  task automatic test_count_wrap();
    do_reset();
    din_valid = 1'b1;
    din_insn  = 32'h00000033;
    repeat (65535) @(posedge clk);
    #1;
    checks++;
    if (ill_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_max got=%h want=ffff", ill_count);
    end
    tick();
    din_valid = 1'b0;
    checks++;
    if ({ill_valid, ill_count} !== {1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL wrap_zero got ill=%b cnt=%h want 1 0000", ill_valid, ill_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_illegal();
    test_xlen();
    test_reset_mid();
    test_random();
    test_count_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
